// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch (I) port, memory-stage (D) port,
// unified memory port and the two performance counters.
// slave  = arbiter side, master = pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            IReq;
    logic [XLEN-1:0] IAddr;
    logic [XLEN-1:0] IRdata;
    logic            DReq;
    logic            DWe;
    logic [XLEN-1:0] DAddr;
    logic [XLEN-1:0] DWdata;
    logic [3:0]      DBe;
    logic [XLEN-1:0] DRdata;
    logic            MemStall;
    logic            MemReq;
    logic            MemWe;
    logic [XLEN-1:0] MemAddr;
    logic [XLEN-1:0] MemWdata;
    logic [3:0]      MemBe;
    logic [XLEN-1:0] MemRdata;
    logic            MemDone;
    logic [31:0]     PerfConf;
    logic [31:0]     PerfStall;

    modport slave (
        input  IReq, IAddr, DReq, DWe, DAddr, DWdata, DBe, MemRdata, MemDone,
        output IRdata, DRdata, MemStall, MemReq, MemWe, MemAddr, MemWdata, MemBe,
               PerfConf, PerfStall
    );

    modport master (
        output IReq, IAddr, DReq, DWe, DAddr, DWdata, DBe, MemRdata, MemDone,
        input  IRdata, DRdata, MemStall, MemReq, MemWe, MemAddr, MemWdata, MemBe,
               PerfConf, PerfStall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (I) and
// memory stage (D). Each port gets at most one access per pipeline advance;
// MemStall freezes the pipeline until every requesting port holds its data.
// D wins conflicts (older instruction) unless it has already won
// MAX_D_STREAK times in a row while I waited.
// Optional macro ARB_PERF_CNT_EN adds conflict/stall cycle counters;
// without it PerfConf/PerfStall are tied to zero.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t          state_q, state_d;
    logic            i_done_q, i_done_d;
    logic            d_done_q, d_done_d;
    logic [XLEN-1:0] i_buf_q, i_buf_d;
    logic [XLEN-1:0] d_buf_q, d_buf_d;
    logic [SW-1:0]   d_streak_q, d_streak_d;

    logic            i_pend, d_pend, mem_stall, advance;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic [3:0]      mem_be;

    // Next-state, grant selection and memory-port drive
    always_comb begin
        i_pend     = bus.IReq & ~i_done_q;
        d_pend     = bus.DReq & ~d_done_q;
        mem_stall  = i_pend | d_pend;
        advance    = ~mem_stall;

        state_d    = state_q;
        // done flags live only while the port keeps requesting and the
        // pipeline has not advanced past it
        i_done_d   = i_done_q & bus.IReq & ~advance;
        d_done_d   = d_done_q & bus.DReq & ~advance;
        i_buf_d    = i_buf_q;
        d_buf_d    = d_buf_q;
        d_streak_d = i_pend ? d_streak_q : '0;

        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = 4'b0000;

        case (state_q)
            IDLE: begin
                if (d_pend && !(i_pend && d_streak_q == SW'(MAX_D_STREAK))) begin
                    state_d = BUSY_D;
                    if (i_pend && d_streak_q != SW'(MAX_D_STREAK))
                        d_streak_d = d_streak_q + SW'(1);
                end else if (i_pend) begin
                    state_d    = BUSY_I;
                    d_streak_d = '0;
                end
            end
            BUSY_I: begin
                mem_req  = 1'b1;
                mem_addr = bus.IAddr;
                if (bus.MemDone) begin
                    i_buf_d  = bus.MemRdata;
                    i_done_d = bus.IReq;
                    state_d  = IDLE;
                end
            end
            BUSY_D: begin
                mem_req   = 1'b1;
                mem_we    = bus.DWe;
                mem_addr  = bus.DAddr;
                mem_wdata = bus.DWdata;
                mem_be    = bus.DBe;
                if (bus.MemDone) begin
                    if (!bus.DWe)
                        d_buf_d = bus.MemRdata;
                    d_done_d = bus.DReq;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, done flags, data buffers and fairness streak
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            i_buf_q    <= '0;
            d_buf_q    <= '0;
            d_streak_q <= '0;
        end else begin
            state_q    <= state_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
            i_buf_q    <= i_buf_d;
            d_buf_q    <= d_buf_d;
            d_streak_q <= d_streak_d;
        end
    end

    assign bus.MemStall = mem_stall;
    assign bus.MemReq   = mem_req;
    assign bus.MemWe    = mem_we;
    assign bus.MemAddr  = mem_addr;
    assign bus.MemWdata = mem_wdata;
    assign bus.MemBe    = mem_be;
    assign bus.IRdata   = i_buf_q;
    assign bus.DRdata   = d_buf_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conf_q, perf_conf_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Free-running wrap-around event counters
    always_comb begin
        perf_conf_d  = perf_conf_q + {31'b0, i_pend & d_pend};
        perf_stall_d = perf_stall_q + {31'b0, mem_stall};
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_conf_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_conf_q  <= perf_conf_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.PerfConf  = perf_conf_q;
    assign bus.PerfStall = perf_stall_q;
`else
    assign bus.PerfConf  = 32'd0;
    assign bus.PerfStall = 32'd0;
`endif
endmodule
